// File: rtl/lagd_fifo_reader.sv
// Pop-side reader for the flip-manager FIFO: drains a burst (or everything until the FIFO is
// empty) into a 2-entry in-order buffer feeding a valid/ready stream.
module lagd_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  burst_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d, count_q, count_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  len_zero, limit, pop, accept;

  // Pop gating uses only registered occupancy, keeping ready_i off the pop path.
  assign len_zero   = (len_q == '0);
  assign limit      = ~len_zero & (count_q == len_q);
  assign pop        = (state_q == ST_RUN) & ~flush_i & ~fifo_empty_i & (occ_q != 2'd2) & ~limit;
  assign accept     = valid_o & ready_i;
  assign fifo_pop_o = pop;
  assign count_o    = count_q;
  assign data_o     = buf0_q;

  // Burst sequencing and popped-entry counter.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          len_d   = burst_len_i;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (pop && (count_q != CNT_MAX)) count_d = count_q + CNT_WIDTH'(1);
        if (limit || (len_zero && fifo_empty_i)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (occ_q == 2'd0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  // In-order two-entry buffer; buf0 is always the head.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case (occ_q)
      2'd0: begin
        if (pop) begin
          buf0_d = fifo_data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && accept) begin
          buf0_d = fifo_data_i;
        end else if (pop) begin
          buf1_d = fifo_data_i;
          occ_d  = 2'd2;
        end else if (accept) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        if (accept) begin
          buf0_d = buf1_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
    if (flush_i) occ_d = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      occ_q   <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      busy_o  <= (state_d != ST_IDLE);
      done_o  <= (state_d == ST_DONE);
      valid_o <= (occ_d != 2'd0);
    end
  end

endmodule

// File: tb/tb_lagd_fifo_reader.sv
// Randomized bench for lagd_fifo_reader: a queue-based FIFO model plus an in-order scoreboard
// of popped-but-unaccepted entries predicts every stream beat, count and completion.
module tb_lagd_fifo_reader;

  localparam int unsigned DW      = 32;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] burst_len_i = '0;
  logic          busy_o, done_o, fifo_pop_o, valid_o;
  logic [CW-1:0] count_o;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_data_i = '0;
  logic [DW-1:0] data_o;
  logic          ready_i = 1'b1;

  always #5 clk_i = ~clk_i;

  lagd_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .start_i(start_i),
    .burst_len_i(burst_len_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            ready_pct = 100;
  int            pops_total, first_pop, last_pop, cyc;
  bit            done_seen, prev_stall;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] done_cnt;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_items(input int n, input bit rnd, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : base + DW'(i));
    drive_fifo();
  endtask

  // One clock: check outputs at the falling edge, then update the models at the rising edge.
  task automatic tick();
    bit pop, acc;
    @(negedge clk_i);
    pop = fifo_pop_o;
    acc = valid_o & ready_i;
    check_eq("pop_while_empty", 64'(pop & fifo_empty_i), 64'(0));
    check_eq("valid", 64'(valid_o), 64'(sb_q.size() != 0));
    if (valid_o && sb_q.size() != 0) check_eq("data", 64'(data_o), 64'(sb_q[0]));
    if (prev_stall && valid_o) check_eq("hold_stable", 64'(data_o), 64'(prev_data));
    check_eq("outstanding_le2", 64'(sb_q.size() <= 2), 64'(1));
    prev_stall = valid_o & ~ready_i;
    prev_data  = data_o;
    done_seen  = done_o;
    if (done_o) done_cnt = count_o;
    @(posedge clk_i);
    if (acc && sb_q.size() != 0) void'(sb_q.pop_front());
    if (pop && fifo_q.size() != 0) begin
      sb_q.push_back(fifo_q.pop_front());
      pops_total++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    cyc++;
    #1;
    drive_fifo();
    ready_i = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run_burst(input int len, input int rpct, input int probe_at, input int probe_pops,
                           input int push_n, input int rpct_after, input bit poke_start,
                           input bit back2back);
    int exp_n, exp_cnt, fifo0;
    exp_n      = (len != 0) ? len : fifo_q.size();
    exp_cnt    = (exp_n > CNT_MAX) ? CNT_MAX : exp_n;
    fifo0      = fifo_q.size() + push_n;
    pops_total = 0;
    first_pop  = -1;
    last_pop   = -1;
    cyc        = 0;
    done_seen  = 0;
    ready_pct  = rpct;
    start_i     = 1'b1;
    burst_len_i = CW'(len);
    tick();
    start_i = 1'b0;
    check_eq("busy_after_start", 64'(busy_o), 64'(1));
    for (int i = 0; i < 300 && !done_seen; i++) begin
      if (cyc == probe_at) begin
        #1;
        if (probe_pops >= 0) begin
          check_eq("probe_pops", 64'(pops_total), 64'(probe_pops));
          check_eq("probe_no_pop", 64'(fifo_pop_o), 64'(0));
          check_eq("probe_busy", 64'(busy_o), 64'(1));
        end
        push_items(push_n, 1'b1, '0);
        ready_pct = rpct_after;
        if (poke_start) begin
          start_i     = 1'b1;
          burst_len_i = CW'(len + 2);
        end
      end
      tick();
      start_i = 1'b0;
    end
    check_eq("done_seen", 64'(done_seen), 64'(1));
    check_eq("done_count", 64'(done_cnt), 64'(exp_cnt));
    check_eq("pops_total", 64'(pops_total), 64'(exp_n));
    check_eq("fifo_residual", 64'(fifo_q.size()), 64'(fifo0 - exp_n));
    check_eq("all_accepted", 64'(sb_q.size()), 64'(0));
    check_eq("done_one_cycle", 64'(done_o), 64'(0));
    check_eq("idle_after_done", 64'(busy_o), 64'(0));
    if (back2back) check_eq("back_to_back", 64'(last_pop - first_pop), 64'(exp_n - 1));
  endtask

  initial begin
    int dn;
    drive_fifo();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_done", 64'(done_o), 64'(0));
    check_eq("rst_count", 64'(count_o), 64'(0));
    check_eq("rst_valid", 64'(valid_o), 64'(0));
    check_eq("rst_data", 64'(data_o), 64'(0));
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // A..E queued, len 3, ready high: back-to-back pops, D and E stay behind.
    push_items(5, 1'b0, 32'hA);
    run_burst(3, 100, -1, -1, 0, 100, 1'b0, 1'b1);
    check_eq("left_head_D", 64'(fifo_q[0]), 64'(32'hD));
    fifo_q.delete();

    // len 4 with ready low: two pops fill the buffer, then release.
    push_items(5, 1'b0, 32'h100);
    run_burst(4, 0, 6, 2, 0, 100, 1'b0, 1'b0);
    fifo_q.delete();

    // Drain-until-empty with two entries, then with none.
    push_items(2, 1'b1, '0);
    run_burst(0, 100, -1, -1, 0, 100, 1'b0, 1'b0);
    drive_fifo();
    run_burst(0, 100, -1, -1, 0, 100, 1'b0, 1'b0);

    // FIFO runs dry after one entry: stall, then refill.
    push_items(1, 1'b1, '0);
    run_burst(3, 100, 8, 1, 2, 100, 1'b0, 1'b0);

    // start_i during RUN must not reload the length.
    push_items(6, 1'b1, '0);
    run_burst(3, 0, 5, 2, 0, 100, 1'b1, 1'b0);
    fifo_q.delete();

    // Flush with a full buffer mid-burst.
    push_items(6, 1'b1, '0);
    ready_pct = 0;
    start_i = 1'b1;
    burst_len_i = CW'(4);
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    flush_i = 1'b1;
    #1 check_eq("pop_in_flush", 64'(fifo_pop_o), 64'(0));
    tick();
    flush_i = 1'b0;
    sb_q.delete();
    check_eq("flush_valid", 64'(valid_o), 64'(0));
    check_eq("flush_busy", 64'(busy_o), 64'(0));
    check_eq("flush_count", 64'(count_o), 64'(0));
    ready_pct = 100;
    dn = 0;
    repeat (5) begin
      tick();
      dn += int'(done_seen);
    end
    check_eq("no_done_after_flush", 64'(dn), 64'(0));
    flush_i = 1'b1;
    start_i = 1'b1;
    burst_len_i = CW'(2);
    tick();
    flush_i = 1'b0;
    start_i = 1'b0;
    check_eq("flush_beats_start", 64'(busy_o), 64'(0));
    tick();
    check_eq("no_pops_in_idle", 64'(fifo_q.size()), 64'(4));
    fifo_q.delete();

    // Asynchronous reset in the middle of a burst.
    push_items(8, 1'b1, '0);
    ready_pct = 0;
    start_i = 1'b1;
    burst_len_i = CW'(5);
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy_o), 64'(0));
    check_eq("arst_valid", 64'(valid_o), 64'(0));
    check_eq("arst_count", 64'(count_o), 64'(0));
    check_eq("arst_data", 64'(data_o), 64'(0));
    check_eq("arst_pop", 64'(fifo_pop_o), 64'(0));
    sb_q.delete();
    prev_stall = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    run_burst(4, 100, -1, -1, 0, 100, 1'b0, 1'b0);
    fifo_q.delete();

    // Counter saturates in drain-until-empty mode while pops continue.
    push_items(20, 1'b1, '0);
    run_burst(0, 100, -1, -1, 0, 100, 1'b0, 1'b1);

    // Random bursts.
    for (int it = 0; it < 25; it++) begin
      int len, rp, pn, pa;
      if (fifo_q.size() > 20) begin
        fifo_q.delete();
        drive_fifo();
      end
      push_items(int'($urandom_range(12)), 1'b1, '0);
      len = int'($urandom_range(10));
      rp  = int'($urandom_range(100, 20));
      pn  = 0;
      pa  = -1;
      if (len != 0 && len > fifo_q.size()) begin
        pn = len - fifo_q.size();
        pa = int'($urandom_range(10, 2));
      end
      run_burst(len, rp, pa, -1, pn, rp, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
